pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter BUBBLE_VAL, default 0 (DATA_W bits), value driven on out_data when the stage holds no valid entry.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream beat present.
REQ-006 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-007 SHALL have port in_ready, output, 1, stage accepts a beat this cycle.
REQ-008 SHALL have port out_valid, output, 1, downstream beat present.
REQ-009 SHALL have port out_data, output, DATA_W, downstream payload.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the beat.
REQ-011 SHALL have port stall, input, 1, freezes the stage (hazard hold).
REQ-012 SHALL have port flush, input, 1, kills all held entries (branch/exception bubble).

Function
REQ-013 SHALL hold two entries: main (drives output) and skid (overflow), each with a valid bit.
REQ-014 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-015 SHALL drive in_ready = !skid_valid & !stall & !flush, combinationally.
REQ-016 SHALL drive out_valid = main_valid & !stall & !flush; out_data = main_data if main_valid, else BUBBLE_VAL.
REQ-017 SHALL, with main empty and in_fire, load main next edge (latency one cycle in_fire to out_valid).
REQ-018 SHALL, with main full, no skid, out_fire and in_fire, replace main with in_data (sustained 1 beat/cycle).
REQ-019 SHALL, with main full, no skid, in_fire and no out_fire, load skid; main unchanged.
REQ-020 SHALL, with skid full and out_fire, move skid to main and clear skid; no beat accepted that cycle.
REQ-021 SHALL, with out_fire and no in_fire and skid empty, clear main_valid.
REQ-022 SHALL preserve order: beats leave in arrival order, none duplicated or lost except by flush.
REQ-023 SHALL, on flush, clear main_valid and skid_valid next edge; flush has priority over stall and all transfers; in_valid beat in that cycle is not accepted.
REQ-024 SHALL, while stall=1 and flush=0, hold all state unchanged.
REQ-025 SHALL leave data registers unchanged when not loaded (only valid bits are cleared by flush).

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear main_valid and skid_valid; outputs then in_ready=1 (if stall=0, flush=0), out_valid=0, out_data=BUBBLE_VAL.
REQ-027 SHALL, on reset asserted mid-operation, discard all entries; first post-release edge behaves as from empty.

Configuration
REQ-028 SHALL, with macro PIPE_STAGE_PERF_EN defined, add outputs stall_cnt[31:0] and kill_cnt[31:0]: stall_cnt increments each cycle stall=1, kill_cnt increments by number of valid entries (0..2) cleared by flush; both saturate at 0xFFFFFFFF, reset to 0.
REQ-029 SHALL, without PIPE_STAGE_PERF_EN, omit those ports and counter logic entirely; function otherwise identical.

Structure
REQ-030 SHALL take DATA_W default, counter width (32) and saturation constant from shared package pipe_pkg.
REQ-031 SHALL place the saturating counters in sub-module pipe_stage_perf, instantiated only under PIPE_STAGE_PERF_EN.

Verification
REQ-032 SHALL cover streaming: in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later, in_ready constantly 1.
REQ-033 SHALL cover backpressure: send 0xA,0xB with out_ready=0 -> in_ready=0 after 2 accepts; raise out_ready -> 0xA then 0xB, in_ready returns 1 after skid drains.
REQ-034 SHALL cover flush: both entries full (0x11,0x22), flush=1 one cycle -> out_valid=0, out_data=BUBBLE_VAL next cycle, 0x11/0x22 never appear; kill_cnt=2 when PIPE_STAGE_PERF_EN.
REQ-035 SHALL cover stall: main=0x55, stall=1 for 3 cycles with in_valid=1, out_ready=1 -> in_ready=0, out_valid=0, state kept; after release 0x55 emitted once; stall_cnt=3.
REQ-036 SHALL cover simultaneous stall+flush and async reset mid-stream: stall=flush=1 -> entries cleared; rst_n low between edges -> out_valid drops immediately, in_ready=1.
REQ-037 SHALL cover parameters DATA_W=1 and DATA_W=64 with BUBBLE_VAL=0xDEAD -> identical ordering, empty output equals 0xDEAD.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants, occupancy encoding and saturating add for the pipeline stage register.
// Included by every file of the pipe_stage_reg slice.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 32;
    localparam logic [CNT_W-1:0] CNT_SAT = 32'hFFFF_FFFF;

    // Bit 0 = main entry valid, bit 1 = skid entry valid.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_MAIN  = 2'b01,
        OCC_FULL  = 2'b11
    } occ_e;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? CNT_SAT : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for pipe_stage_reg: upstream (in_*) and downstream (out_*) sides.
// slave = the stage itself, master = its surroundings (producer and consumer).
interface pipe_stage_reg_if #(
    parameter int DATA_W = pipe_pkg::DATA_W_DEF
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_perf.sv
// Saturating stall and flush-kill counters for pipe_stage_reg.
// Instantiated only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_perf
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [1:0]       kill_num,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] kill_cnt
);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;

    always_comb begin
        stall_cnt_d = stall ? sat_add(stall_cnt_q, 2'd1) : stall_cnt_q;
        kill_cnt_d  = sat_add(kill_cnt_q, kill_num);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign kill_cnt  = kill_cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with stall, flush and bubble output.
// Optional perf counters (stall_cnt, kill_cnt) when PIPE_STAGE_PERF_EN is defined.
//
// state     | meaning
// OCC_EMPTY | no valid entry, out_data = BUBBLE_VAL
// OCC_MAIN  | main holds a beat, skid free
// OCC_FULL  | main and skid hold beats, in_ready low
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] kill_cnt
`endif
);

    occ_e              occ_q, occ_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic main_valid, skid_valid;
    logic in_ready, out_valid, in_fire, out_fire;

    assign main_valid = occ_q[0];
    assign skid_valid = occ_q[1];
    assign in_ready   = !skid_valid && !stall && !flush;
    assign out_valid  = main_valid && !stall && !flush;
    assign in_fire    = bus.in_valid && in_ready;
    assign out_fire   = out_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_valid ? main_data_q : BUBBLE_VAL;

    always_comb begin
        occ_d       = occ_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else if (!stall) begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        main_data_d = bus.in_data;
                        occ_d       = OCC_MAIN;
                    end
                end
                OCC_MAIN: begin
                    if (in_fire && out_fire) begin
                        main_data_d = bus.in_data;
                    end else if (in_fire) begin
                        skid_data_d = bus.in_data;
                        occ_d       = OCC_FULL;
                    end else if (out_fire) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so only the drain path exists
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        occ_d       = OCC_MAIN;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Payload registers carry no reset; the bubble mux hides them while empty.
    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [1:0] kill_num;
    assign kill_num = flush ? ({1'b0, main_valid} + {1'b0, skid_valid}) : 2'd0;

    pipe_stage_perf u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .kill_num  (kill_num),
        .stall_cnt (stall_cnt),
        .kill_cnt  (kill_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (32b, 64b/0xDEAD bubble, 1b) on shared controls.
// Covers streaming, backpressure, flush, stall, stall+flush, async reset and optional perf counters.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_stage_reg_if #(.DATA_W(32)) bus32 ();
    pipe_stage_reg_if #(.DATA_W(64)) bus64 ();
    pipe_stage_reg_if #(.DATA_W(1))  bus1  ();

    assign bus32.in_valid  = in_valid;
    assign bus32.in_data   = in_data;
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.in_data   = {~in_data, in_data};
    assign bus64.out_ready = out_ready;
    assign bus1.in_valid   = in_valid;
    assign bus1.in_data    = in_data[0];
    assign bus1.out_ready  = out_ready;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt32, kill_cnt32, stall_cnt64, kill_cnt64, stall_cnt1, kill_cnt1;
`endif

    pipe_stage_reg #(.DATA_W(32), .BUBBLE_VAL(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .bus(bus32)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt32), .kill_cnt(kill_cnt32)
`endif
    );

    pipe_stage_reg #(.DATA_W(64), .BUBBLE_VAL(64'hDEAD)) dut64 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .bus(bus64)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt64), .kill_cnt(kill_cnt64)
`endif
    );

    pipe_stage_reg #(.DATA_W(1), .BUBBLE_VAL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .bus(bus1)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt1), .kill_cnt(kill_cnt1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // emv/emd: whether main holds a beat and its 32-bit payload
    task automatic chk(input string tag, input logic eir, input logic eov,
                       input logic emv, input logic [31:0] emd);
        chk1({tag, ".in_ready"},  {63'b0, bus32.in_ready},  {63'b0, eir});
        chk1({tag, ".out_valid"}, {63'b0, bus32.out_valid}, {63'b0, eov});
        chk1({tag, ".out_data"},  {32'b0, bus32.out_data},  emv ? {32'b0, emd} : 64'h0);
        chk1({tag, ".w64_valid"}, {63'b0, bus64.out_valid}, {63'b0, eov});
        chk1({tag, ".w64_data"},  bus64.out_data,           emv ? {~emd, emd} : 64'hDEAD);
        chk1({tag, ".w1_valid"},  {63'b0, bus1.out_valid},  {63'b0, eov});
        chk1({tag, ".w1_data"},   {63'b0, bus1.out_data},   emv ? {63'b0, emd[0]} : 64'h1);
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic chk_cnt(input string tag, input logic [31:0] es, input logic [31:0] ek);
        chk1({tag, ".stall_cnt"}, {32'b0, stall_cnt32}, {32'b0, es});
        chk1({tag, ".kill_cnt"},  {32'b0, kill_cnt32},  {32'b0, ek});
        chk1({tag, ".stall_cnt64"}, {32'b0, stall_cnt64}, {32'b0, es});
        chk1({tag, ".kill_cnt1"},  {32'b0, kill_cnt1},  {32'b0, ek});
    endtask
`endif

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 32'h0;
        #3;
        chk("reset", 1'b1, 1'b0, 1'b0, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
        chk_cnt("reset", 32'd0, 32'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // streaming: 1,2,3,4 back to back, each visible one cycle later
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'(i);
            #1;
            if (i == 1) chk("stream_first", 1'b1, 1'b0, 1'b0, 32'h0);
            else        chk("stream", 1'b1, 1'b1, 1'b1, 32'(i - 1));
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("stream_last", 1'b1, 1'b1, 1'b1, 32'h4);
        tick();
        chk("stream_empty", 1'b1, 1'b0, 1'b0, 32'h0);

        // backpressure: A then B fill main and skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        #1;
        chk("bp_a_pre", 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        in_data = 32'hB;
        #1;
        chk("bp_b_pre", 1'b1, 1'b1, 1'b1, 32'hA);
        tick();
        in_valid = 1'b0;
        #1;
        chk("bp_full", 1'b0, 1'b1, 1'b1, 32'hA);
        tick();
        chk("bp_hold", 1'b0, 1'b1, 1'b1, 32'hA);
        out_ready = 1'b1;
        #1;
        chk("bp_drain_a", 1'b0, 1'b1, 1'b1, 32'hA);
        tick();
        chk("bp_drain_b", 1'b1, 1'b1, 1'b1, 32'hB);
        tick();
        chk("bp_empty", 1'b1, 1'b0, 1'b0, 32'h0);

        // flush with both entries full; 0x33 offered during flush must be dropped
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        in_valid = 1'b0;
        #1;
        chk("fl_full", 1'b0, 1'b1, 1'b1, 32'h11);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h33;
        #1;
        chk("fl_active", 1'b0, 1'b0, 1'b1, 32'h11);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("fl_after", 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("fl_after2", 1'b1, 1'b0, 1'b0, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
        chk_cnt("fl_cnt", 32'd0, 32'd2);
`endif

        // stall: main holds 0x55 for three stalled cycles, then emits once
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        tick();
        stall     = 1'b1;
        in_data   = 32'h66;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_hold", 1'b0, 1'b0, 1'b1, 32'h55);
            tick();
        end
        stall    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("st_release", 1'b1, 1'b1, 1'b1, 32'h55);
        tick();
        chk("st_empty", 1'b1, 1'b0, 1'b0, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
        chk_cnt("st_cnt", 32'd3, 32'd2);
`endif

        // stall and flush together: flush wins
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h77;
        tick();
        in_data = 32'h88;
        tick();
        in_valid = 1'b0;
        stall    = 1'b1;
        flush    = 1'b1;
        #1;
        chk("sf_active", 1'b0, 1'b0, 1'b1, 32'h77);
        tick();
        stall = 1'b0;
        flush = 1'b0;
        #1;
        chk("sf_after", 1'b1, 1'b0, 1'b0, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
        chk_cnt("sf_cnt", 32'd4, 32'd4);
`endif

        // async reset between edges mid-stream
        in_valid = 1'b1;
        in_data  = 32'h99;
        tick();
        in_valid = 1'b0;
        #1;
        chk("ar_loaded", 1'b1, 1'b1, 1'b1, 32'h99);
        rst_n = 1'b0;
        #1;
        chk("ar_async", 1'b1, 1'b0, 1'b0, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
        chk_cnt("ar_cnt", 32'd0, 32'd0);
`endif
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hAB;
        #1;
        chk("ar_post_pre", 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("ar_post", 1'b1, 1'b1, 1'b1, 32'hAB);
        tick();
        chk("ar_post_empty", 1'b1, 1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
